regfile_mp: RTL



---
 rtl/regfile_mp.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: integer register file with one write port, NRP combinational read ports,
// hardwired x0 and a clear sequencer. Same-cycle write forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRP   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic                busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic            busy_q;
    logic            busy_d;
    logic            clr_wr_s;
    logic            usr_wr_s;
    // x0 is never stored; index 0 is answered by the read mux
    logic [XLEN-1:0] rf_q [1:NREGS-1];

    // Clear sequencer next state; busy_d mirrors the next state so busy is a pure flop
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        if (rst) begin
            state_d = ST_CLEAR;
            ptr_d   = PTR_FIRST;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_d = ST_CLEAR;
                        ptr_d   = PTR_FIRST;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        busy_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = PTR_FIRST;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        busy_q  <= busy_d;
    end

    // Array write strobes: the sequencer owns the array while clearing, rst blocks all writes
    always_comb begin
        clr_wr_s = 1'b0;
        usr_wr_s = 1'b0;
        if (!rst && (state_q == ST_CLEAR)) begin
            clr_wr_s = 1'b1;
        end else if (!rst && (state_q == ST_IDLE) && we && (waddr != '0)) begin
            usr_wr_s = 1'b1;
        end else begin
            clr_wr_s = 1'b0;
            usr_wr_s = 1'b0;
        end
    end

    // Register array storage
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            rf_q[ptr_q] <= '0;
        end else if (usr_wr_s) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Per-port read mux in priority order: busy, x0, optional forward, array
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NRP; p++) begin
            if (busy_q) begin
                rdata[p*XLEN +: XLEN] = '0;
            end else if (raddr[p*AW +: AW] == '0) begin
                rdata[p*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (we && (waddr == raddr[p*AW +: AW])) begin
                rdata[p*XLEN +: XLEN] = wdata;
`endif
            end else begin
                rdata[p*XLEN +: XLEN] = rf_q[raddr[p*AW +: AW]];
            end
        end
    end

    assign busy = busy_q;

endmodule
